// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (sense chosen by ODD_PARITY).
module uart_tx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  output logic       baud_en,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd,
  output logic [2:0] state_dbg
);

  // Handshake: a request is taken only in IDLE (tx_start=1 there); tx_busy rises the
  // next cycle and tx_done pulses, with tx_busy low, in the cycle after the last stop tick.

  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_bad_param
    $error("uart_tx_framer: illegal parameter value");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       stop_q, stop_d;
  logic       done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        // tick is deliberately ignored here; only tx_start matters
        if (tx_start) begin
          shift_d  = tx_data;
          idx_d    = '0;
          stop_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = 1'b0;
`endif
          state_d  = START;
        end
      end
      START: begin
        if (tick) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d  = {1'b0, shift_q[7:1]};
          idx_d    = idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          parity_d = parity_q ^ shift_q[0];
          if (idx_q == LAST_IDX) state_d = PARITY;
`else
          if (idx_q == LAST_IDX) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          stop_d = stop_q + 1'b1;
          if (STOP_BITS == 1 || stop_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come only from registers, so no input reaches an output combinationally.
  always_comb begin
    txd = 1'b1;
    case (state_q)
      START:   txd = 1'b0;
      DATA:    txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd = parity_q ^ 1'(ODD_PARITY);
`endif
      default: txd = 1'b1;
    endcase
  end

  assign tx_busy   = (state_q != IDLE);
  assign baud_en   = (state_q != IDLE);
  assign tx_done   = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: reset, frames, busy drop, back-to-back, parity, mid-frame reset.
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
  localparam int STOP_N = 2;
  localparam int PAR_N  = 1;
`else
  localparam int STOP_N = 1;
  localparam int PAR_N  = 0;
`endif
  localparam int FRAME_N = 1 + 8 + PAR_N + STOP_N;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       baud_en, tx_busy, tx_done, txd;
  logic [2:0] state_dbg;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(STOP_N), .ODD_PARITY(0)) dut (
    .clk(clk), .rst(rst), .tick(tick), .baud_en(baud_en), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done), .txd(txd), .state_dbg(state_dbg)
  );

`ifdef UART_TX_PARITY_EN
  logic       baud_en_o, tx_busy_o, tx_done_o, txd_o;
  logic [2:0] state_dbg_o;
  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(STOP_N), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst(rst), .tick(tick), .baud_en(baud_en_o), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy_o), .tx_done(tx_done_o), .txd(txd_o), .state_dbg(state_dbg_o)
  );
`endif

  // scoreboard
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  logic [0:0] exp_o_q[$];
  logic [0:0] got_o_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int idle_low_cnt = 0;
  int done_busy_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // tick generator: one pulse every 16 clocks while enabled, phase restarts when disabled
  bit force_tick = 1'b0;
  int tick_cnt = 0;
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (force_tick || baud_en === 1'b1) begin
        if (tick_cnt == 15) begin
          tick = 1'b1;
          tick_cnt = 0;
        end else begin
          tick = 1'b0;
          tick_cnt++;
        end
      end else begin
        tick = 1'b0;
        tick_cnt = 0;
      end
    end
  end

  // line monitor: record the bit on the line at each tick while busy
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (tick && tx_busy) got_q.push_back(txd);
`ifdef UART_TX_PARITY_EN
      if (tick && tx_busy_o) got_o_q.push_back(txd_o);
`endif
      if (tx_done) done_cnt++;
      if (tx_done && tx_busy) done_busy_cnt++;
      if (!tx_busy && !txd) idle_low_cnt++;
    end
  end

  // driver tasks
  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    exp_o_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      exp_o_q.push_back(d[i]);
    end
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^d);
    exp_o_q.push_back(~^d);
`endif
    for (int i = 0; i < STOP_N; i++) begin
      exp_q.push_back(1'b1);
      exp_o_q.push_back(1'b1);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    exp_o_q.delete();
    got_o_q.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [7:0] d);
    @(posedge clk);
    #1;
    tx_start = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size()) check($sformatf("%s_bit%0d", tag, i), got_q[i], exp_q[i]);
`ifdef UART_TX_PARITY_EN
    check({tag, "_odd_len"}, got_o_q.size(), exp_o_q.size());
    foreach (exp_o_q[i])
      if (i < got_o_q.size()) check($sformatf("%s_odd_bit%0d", tag, i), got_o_q[i], exp_o_q[i]);
`endif
  endtask

  initial begin
`ifdef UART_TX_PARITY_EN
    logic [11:0] a5_line;
`else
    logic [9:0]  a5_line;
`endif
    bit reached;
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;

    // 1: reset held 3 cycles, then idle ticks change nothing
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_baud_en", baud_en, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_state", state_dbg, 3'd0);
    force_tick = 1'b1;
    repeat (64) @(negedge clk);
    force_tick = 1'b0;
    check("idle_tick_txd", txd, 1'b1);
    check("idle_tick_busy", tx_busy, 1'b0);
    check("idle_tick_low", idle_low_cnt, 0);
    check("idle_tick_done", done_cnt, 0);

    // 2: single frame 0xA5
    clear_sb();
    push_frame(8'hA5);
    send(8'hA5);
    wait_done("a5");
    repeat (3) @(negedge clk);
    compare_frames("a5");
`ifdef UART_TX_PARITY_EN
    a5_line = 12'b110101001010;
`else
    a5_line = 10'b1101001010;
`endif
    for (int i = 0; i < FRAME_N; i++)
      if (i < got_q.size()) check($sformatf("a5_line%0d", i), got_q[i], a5_line[i]);
    check("a5_busy_ticks", got_q.size(), FRAME_N);
    check("a5_done_cnt", done_cnt, 1);

    // 3: request while busy is dropped
    clear_sb();
    push_frame(8'hFF);
    send(8'hFF);
    repeat (40) @(negedge clk);
    send(8'h3C);
    wait_done("ff");
    repeat (60) @(negedge clk);
    compare_frames("ff");
    check("ff_done_cnt", done_cnt, 1);
    check("ff_idle_after", tx_busy, 1'b0);

    // 4: tx_start held high -> back-to-back frames with a one-clock gap
    clear_sb();
    push_frame(8'h55);
    push_frame(8'h0F);
    @(posedge clk);
    #1;
    tx_start = 1'b1;
    tx_data  = 8'h55;
    @(posedge clk);
    #1 tx_data = 8'h0F;
    wait_done("b2b1");
    check("b2b_gap_txd", txd, 1'b1);
    check("b2b_gap_baud_en", baud_en, 1'b0);
    check("b2b_gap_busy", tx_busy, 1'b0);
    @(posedge clk);
    #1 tx_start = 1'b0;
    @(negedge clk);
    check("b2b_start_txd", txd, 1'b0);
    check("b2b_start_busy", tx_busy, 1'b1);
    wait_done("b2b2");
    repeat (3) @(negedge clk);
    compare_frames("b2b");
    check("b2b_done_cnt", done_cnt, 2);

`ifdef UART_TX_PARITY_EN
    // 5: parity, two stop bits, 0x07
    clear_sb();
    push_frame(8'h07);
    send(8'h07);
    wait_done("par");
    repeat (3) @(negedge clk);
    compare_frames("par");
    check("par_frame_len", got_q.size(), 12);
    if (got_q.size() > 9) check("par_even_bit", got_q[9], 1'b1);
    if (got_o_q.size() > 9) check("par_odd_bit", got_o_q[9], 1'b0);
`endif

    // 6: reset during data bit 3 aborts, next frame is clean
    clear_sb();
    send(8'h00);
    reached = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (got_q.size() >= 4) begin
        reached = 1'b1;
        break;
      end
    end
    check("abort_reach_bit3", reached, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_txd", txd, 1'b1);
    check("abort_busy", tx_busy, 1'b0);
    check("abort_baud_en", baud_en, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    clear_sb();
    push_frame(8'h5A);
    send(8'h5A);
    wait_done("post");
    repeat (3) @(negedge clk);
    compare_frames("post");
    check("post_done_cnt", done_cnt, 1);
    check("done_with_busy", done_busy_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Serial transmit framer that sits directly downstream of the baud tick generator in the UART datapath. It accepts a parallel byte through a start/busy handshake, gates the tick generator through `baud_en`, and shifts out a start bit, data bits LSB-first, an optional parity bit and stop bits, one bit per `tick`. It signals completion with a one-cycle `tx_done` pulse so the host can stream bytes back-to-back.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal values 5–8.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `ODD_PARITY`, 0: parity sense when parity is compiled in. 0 = even, 1 = odd.

- `clk`  in  1  system clock; the same clock as the tick generator.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle baud pulse from the tick generator; Oversampling = 1.
- `baud_en`  out  1  drives the tick generator's `enable`. It is high only while a frame is in flight.
- `tx_start`  in  1  request to send `tx_data`; sampled every cycle.
- `tx_data`  in  8  byte to send; only bits `[DATA_BITS-1:0]` are used.
- `tx_busy`  out  1  high from the cycle after acceptance until the frame ends.
- `tx_done`  out  1  one-cycle pulse in the cycle after the final stop-bit tick.
- `txd`  out  1  serial line; idle level is high.

## Operation
- Reset values: `txd`=1, `tx_busy`=0, `tx_done`=0, `baud_en`=0, state=IDLE. Reset clears all counters and the shift register.
- State machine:
  - **IDLE**: `txd`=1. When `tx_start`=1, the block latches `tx_data`, clears the parity accumulator and moves to START.
  - **START**: `txd`=0. On `tick`, moves to DATA with bit index 0.
  - **DATA**: `txd`=shift[0].
    - On `tick`, shifts right, XORs the sent bit into parity and increments the index.
    - After bit `DATA_BITS-1`, moves to PARITY if parity is compiled in, otherwise to STOP.
  - **PARITY**: `txd`=parity ^ `ODD_PARITY`. On `tick`, moves to STOP.
  - **STOP**: `txd`=1.
    - Each `tick` increments the stop counter.
    - On the `STOP_BITS`-th tick, moves to IDLE and asserts `tx_done` for one cycle.
- `tx_busy` and `baud_en` are high in every state except IDLE.
- `tx_start` while busy is ignored; the request is dropped, not queued.
- `tick` in IDLE is ignored.
- `tx_data` changes after acceptance do not affect the frame in flight.
- `baud_en` falls in the same cycle that IDLE is entered. The tick generator then reloads its phase, so every frame's bit timing starts fresh.
- Bit index width is 3 bits. The stop counter is 1 bit and wraps only in the 2-stop-bit case.
- `rst` asserted mid-frame aborts immediately: `txd` returns to 1 and no `tx_done` is generated.

## Timing
- Acceptance, cycle N: `tx_start`=1 and the state is IDLE.
- Cycle N+1: `txd`=0, `tx_busy`=1, `baud_en`=1.
- Each `txd` transition is registered and appears in the cycle after the `tick` that ends the previous bit.
- Start-bit length = (first tick after `baud_en` rises) − (N+1), plus 1 cycle. The tick generator guarantees this is one bit period within its accuracy.
- Frame length = 1 + `DATA_BITS` + parity (0 or 1) + `STOP_BITS` ticks.
- `tx_done` and `tx_busy`=0 appear together in the cycle after the last stop tick.
- `tx_start` is accepted in that same cycle. In that case the start bit begins in the following cycle, so the line is held high for exactly one extra clock. This is the back-to-back case.
- `tick` and `tx_start` arriving together in IDLE: `tx_start` is accepted and `tick` is ignored.
- No combinational path runs from any input to any output.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in; the frame carries one parity bit between data and stop.
  - Parity = XOR of the sent data bits, inverted when `ODD_PARITY`=1.
- `UART_TX_PARITY_EN` undefined:
  - The PARITY state and accumulator are absent; DATA goes directly to STOP.
  - `ODD_PARITY` has no effect.

## Test plan
1. Reset with `rst` held 3 cycles, then released → `txd`=1, `tx_busy`=0, `baud_en`=0, `tx_done`=0. Ticks injected every 16 clocks leave `txd` unchanged.
2. Defaults, ticks every 16 clocks while `baud_en`=1, send 0xA5 → line shows 0,1,0,1,0,0,1,0,1,1, one bit per tick. `tx_done` pulses once; `tx_busy` is high for exactly 10 ticks.
3. `tx_start` pulsed with 0x3C while busy sending 0xFF → the second request is ignored. Exactly one frame is sent, carrying 0xFF.
4. `tx_start` held high continuously with 0x55, then 0x0F → two frames are sent. Between them the line is high for exactly 1 clock after the `tx_done` cycle; `baud_en` drops for that cycle.
5. `UART_TX_PARITY_EN`, `ODD_PARITY`=0, `STOP_BITS`=2, send 0x07 → parity bit 1, followed by two stop ticks, for a frame of 12 ticks. With `ODD_PARITY`=1 the parity bit is 0.
6. `rst` asserted during data bit 3 of 0x00 → `txd`=1 and `tx_busy`=0 immediately, with no `tx_done`. The next `tx_start` sends a complete, correct frame.
